// File: rtl/handshake_tx.sv
// 4-phase request/acknowledge transmitter: accepts one word while idle, holds it on data_out
// and runs one req/ack handshake against an asynchronous receiver, with a per-phase timeout.
module handshake_tx #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             req_out,
    output logic [WIDTH-1:0] data_out,
    input  logic             ack_in,
    input  logic             err_clr,
    output logic             busy,
    output logic             timeout_err
);
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO, ERR} state_t;

    state_t             state_q, state_d;
    logic               req_q, req_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ack_s1_q, ack_s2_q;
    logic               timed_out;

    // ack_in is asynchronous to clk; only the second stage is ever looked at.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_s1_q <= 1'b0;
            ack_s2_q <= 1'b0;
        end else begin
            ack_s1_q <= ack_in;
            ack_s2_q <= ack_s1_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign timed_out = (cnt_q == CNT_LAST);

    // NOTE: every signal gets its hold value first, so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    data_d  = in_data;
                    req_d   = 1'b1;
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                // A real ack beats a timeout that lands on the same edge.
                if (ack_s2_q) begin
                    req_d   = 1'b0;
                    state_d = WAIT_LO;
                end else if (timed_out) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ERR;
                end
            end
            WAIT_LO: begin
                if (!ack_s2_q) begin
                    state_d = IDLE;
                end else if (timed_out) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ERR;
                end
            end
            ERR: begin
                // Leave only once the receiver has released ack, so the next word starts clean.
                if (err_clr && !ack_s2_q) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == WAIT_HI || state_q == WAIT_LO) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign in_ready    = (state_q == IDLE) && !ack_s2_q;
    assign req_out     = req_q;
    assign data_out    = data_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = err_q;

endmodule

// File: tb/tb_handshake_tx.sv
// Bench for handshake_tx: directed handshake scenarios with hand-derived edge timings, then a
// long randomized run against a transaction-level model of the sender.
module tb_handshake_tx;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 16;

    localparam int M_IDLE  = 0;
    localparam int M_AWAIT_HI = 1;
    localparam int M_AWAIT_LO = 2;
    localparam int M_FAULT = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             req_out;
    logic [WIDTH-1:0] data_out;
    logic             ack_in = 1'b0;
    logic             err_clr = 1'b0;
    logic             busy;
    logic             timeout_err;

    int checks = 0;
    int errors = 0;

    // Reference model state: mode, the edge at which the mode was entered, and the last two
    // sampled ack_in values (the receiver's ack as seen two edges late).
    int               m_mode;
    int               m_since;
    int               m_edge;
    logic             m_req;
    logic             m_err;
    logic [WIDTH-1:0] m_data;
    logic             m_a1, m_a2;

    always #5 clk = ~clk;

    handshake_tx #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .req_out    (req_out),
        .data_out   (data_out),
        .ack_in     (ack_in),
        .err_clr    (err_clr),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; in_data = '0; ack_in = 1'b0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Receiver mirrors req_out with one cycle of lag until the sender is idle again.
    task automatic drain();
        logic done;
        done = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (!busy) begin
                done = 1'b1;
                break;
            end
            ack_in = req_out;
            @(negedge clk);
        end
        ack_in = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL drain: busy never dropped within 100 cycles");
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({req_out, data_out, busy, timeout_err, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_hold: req/data/busy/err/rdy got %b/%h/%b/%b/%b want 0/00/0/0/1",
                     req_out, data_out, busy, timeout_err, in_ready);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_out, busy, timeout_err, in_ready} !== {1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_release: req/busy/err/rdy got %b/%b/%b/%b want 0/0/0/1",
                     req_out, busy, timeout_err, in_ready);
        end
    endtask

    // ack_in follows req_out through a 5-cycle delay line.
    task automatic test_normal();
        logic [4:0] dly;
        int rise_n, fall_n, idle_n;
        logic rdy_at_idle, data_ok;
        do_reset();
        dly = '0; rise_n = -1; fall_n = -1; idle_n = -1; rdy_at_idle = 1'b0; data_ok = 1'b1;
        in_valid = 1'b1; in_data = 8'hA5;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (req_out !== 1'b1 || data_out !== 8'hA5) begin
            errors++;
            $display("FAIL normal_accept: req/data got %b/%h want 1/a5", req_out, data_out);
        end
        for (int n = 1; n <= 22; n++) begin
            if (!req_out && fall_n < 0) fall_n = n;
            if (!busy && idle_n < 0) begin
                idle_n = n;
                rdy_at_idle = in_ready;
            end
            if (data_out !== 8'hA5) data_ok = 1'b0;
            ack_in = dly[4];
            if (ack_in && rise_n < 0) rise_n = n;
            dly = {dly[3:0], req_out};
            @(negedge clk);
        end
        checks++;
        if (rise_n != 6 || fall_n != 9) begin
            errors++;
            $display("FAIL normal_req_fall: ack rose at %0d, req fell at %0d, want 6 and 9", rise_n, fall_n);
        end
        checks++;
        if (idle_n != 17 || rdy_at_idle !== 1'b1) begin
            errors++;
            $display("FAIL normal_idle: idle at %0d rdy %b, want 17 rdy 1", idle_n, rdy_at_idle);
        end
        checks++;
        if (data_ok !== 1'b1 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL normal_hold: data_ok %b err %b want 1/0", data_ok, timeout_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] dly;
        logic [WIDTH-1:0] seq [2];
        logic [WIDTH-1:0] held;
        logic prev_req;
        int nrise, bad_hold;
        do_reset();
        dly = '0; prev_req = 1'b0; nrise = 0; bad_hold = 0; held = '0;
        seq[0] = '0; seq[1] = '0;
        in_valid = 1'b1; in_data = 8'h01;
        for (int n = 0; n < 60; n++) begin
            if (req_out && prev_req && data_out !== held) bad_hold++;
            if (req_out && !prev_req) begin
                if (nrise < 2) seq[nrise] = data_out;
                nrise++;
                held = data_out;
                if (nrise == 1) in_data = 8'h02;
                else in_valid = 1'b0;
            end
            prev_req = req_out;
            ack_in = dly[4];
            dly = {dly[3:0], req_out};
            @(negedge clk);
        end
        checks++;
        if (nrise != 2 || seq[0] !== 8'h01 || seq[1] !== 8'h02) begin
            errors++;
            $display("FAIL b2b_order: %0d transfers, words %h %h, want 2 transfers 01 02",
                     nrise, seq[0], seq[1]);
        end
        checks++;
        if (bad_hold != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_hold: %0d data changes under req, busy %b, want 0 and 0", bad_hold, busy);
        end
    endtask

    task automatic test_timeout();
        logic [WIDTH-1:0] d;
        do_reset();
        d = 8'($urandom_range(1, 255));
        in_valid = 1'b1; in_data = d;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (15) @(negedge clk);
        checks++;
        if (req_out !== 1'b1 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: cycle 15 req/err got %b/%b want 1/0", req_out, timeout_err);
        end
        @(negedge clk);
        checks++;
        if ({req_out, timeout_err, busy, in_ready} !== 4'b0110 || data_out !== d) begin
            errors++;
            $display("FAIL timeout_err: req/err/busy/rdy/data got %b/%b/%b/%b/%h want 0/1/1/0/%h",
                     req_out, timeout_err, busy, in_ready, data_out, d);
        end
        // A late ack while in ERR must hold off err_clr until it is released.
        ack_in = 1'b1;
        repeat (3) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        ack_in = 1'b0;
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_clr_blocked: err/busy got %b/%b want 1/1", timeout_err, busy);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: err got %b want 1", timeout_err);
        end
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if ({timeout_err, busy, in_ready, req_out} !== 4'b0010 || data_out !== d) begin
            errors++;
            $display("FAIL timeout_clear: err/busy/rdy/req/data got %b/%b/%b/%b/%h want 0/0/1/0/%h",
                     timeout_err, busy, in_ready, req_out, data_out, d);
        end
    endtask

    // Synchronized ack arrives exactly on the edge where the wait would otherwise expire.
    task automatic test_priority();
        do_reset();
        in_valid = 1'b1; in_data = 8'h3C;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (13) @(negedge clk);
        ack_in = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (req_out !== 1'b1) begin
            errors++;
            $display("FAIL prio_pre: req got %b want 1", req_out);
        end
        @(negedge clk);
        checks++;
        if ({req_out, busy, timeout_err} !== 3'b010) begin
            errors++;
            $display("FAIL prio_exit: req/busy/err got %b/%b/%b want 0/1/0", req_out, busy, timeout_err);
        end
        ack_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, timeout_err, in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL prio_idle: busy/err/rdy got %b/%b/%b want 0/0/1", busy, timeout_err, in_ready);
        end
    endtask

    task automatic test_stale_ack();
        logic [WIDTH-1:0] d;
        do_reset();
        d = 8'($urandom_range(1, 255));
        ack_in = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stale_ready: rdy got %b want 0", in_ready);
        end
        in_valid = 1'b1; in_data = d;
        repeat (3) @(negedge clk);
        ack_in = 1'b0;
        checks++;
        if (busy !== 1'b0 || req_out !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stale_block: busy/req/rdy got %b/%b/%b want 0/0/0", busy, req_out, in_ready);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stale_release: busy/rdy got %b/%b want 0/1", busy, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || req_out !== 1'b1 || data_out !== d) begin
            errors++;
            $display("FAIL stale_accept: busy/req/data got %b/%b/%h want 1/1/%h", busy, req_out, data_out, d);
        end
        drain();
    endtask

    task automatic test_mid_reset();
        logic [WIDTH-1:0] d;
        do_reset();
        d = 8'($urandom_range(1, 255));
        in_valid = 1'b1; in_data = d;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        ack_in = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (req_out !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_setup: req/busy got %b/%b want 0/1", req_out, busy);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({req_out, busy, timeout_err, in_ready} !== 4'b0001 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL midrst_lo: req/busy/err/rdy/data got %b/%b/%b/%b/%h want 0/0/0/1/00",
                     req_out, busy, timeout_err, in_ready, data_out);
        end
        ack_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_data = ~d;
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (req_out !== 1'b0 || busy !== 1'b0 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL midrst_hi: req/busy/data got %b/%b/%h want 0/0/00", req_out, busy, data_out);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h5A;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (req_out !== 1'b1 || data_out !== 8'h5A) begin
            errors++;
            $display("FAIL midrst_after: req/data got %b/%h want 1/5a", req_out, data_out);
        end
        drain();
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_since = 0; m_edge = 0;
        m_req = 1'b0; m_err = 1'b0; m_data = '0; m_a1 = 1'b0; m_a2 = 1'b0;
    endtask

    // One rising edge of the sender as described behaviourally: a phase gives up once it has
    // waited TIMEOUT edges, unless the awaited ack level is seen on that same edge.
    task automatic model_edge();
        int waited;
        logic seen;
        m_edge++;
        waited = m_edge - m_since;
        seen = m_a2;
        if (m_mode == M_IDLE) begin
            if (in_valid && !seen) begin
                m_data = in_data; m_req = 1'b1; m_mode = M_AWAIT_HI; m_since = m_edge;
            end
        end else if (m_mode == M_AWAIT_HI || m_mode == M_AWAIT_LO) begin
            if (m_mode == M_AWAIT_HI && seen) begin
                m_req = 1'b0; m_mode = M_AWAIT_LO; m_since = m_edge;
            end else if (m_mode == M_AWAIT_LO && !seen) begin
                m_mode = M_IDLE; m_since = m_edge;
            end else if (waited == TIMEOUT) begin
                m_req = 1'b0; m_err = 1'b1; m_mode = M_FAULT; m_since = m_edge;
            end
        end else if (err_clr && !seen) begin
            m_err = 1'b0; m_mode = M_IDLE; m_since = m_edge;
        end
        m_a2 = m_a1;
        m_a1 = ack_in;
    endtask

    task automatic test_random();
        int p;
        logic exp_busy, exp_rdy;
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            p = (i < 1000) ? 60 : (i < 2000) ? 25 : 6;
            in_valid = 1'($urandom_range(0, 1));
            in_data = 8'($urandom);
            err_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) < p) ack_in = req_out;
            else if ($urandom_range(0, 99) < 2) ack_in = 1'($urandom_range(0, 1));
            model_edge();
            @(negedge clk);
            exp_busy = (m_mode != M_IDLE);
            exp_rdy = (m_mode == M_IDLE) && !m_a2;
            checks++;
            if ({req_out, data_out, busy, timeout_err, in_ready} !==
                {m_req, m_data, exp_busy, m_err, exp_rdy}) begin
                errors++;
                $display("FAIL random cyc %0d: req/data/busy/err/rdy got %b/%h/%b/%b/%b want %b/%h/%b/%b/%b",
                         i, req_out, data_out, busy, timeout_err, in_ready,
                         m_req, m_data, exp_busy, m_err, exp_rdy);
            end
        end
        in_valid = 1'b0; err_clr = 1'b0; ack_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_back_to_back();
        test_timeout();
        test_priority();
        test_stale_ack();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
